// File: rtl/target_lut_pkg.sv
// Shared types and constants for the programmable branch/immediate target table.
// Optional feature macro: TARGET_LUT_BYPASS_EN (write-to-read forwarding on a
// same-cycle load beat and read of the same index).
package target_lut_pkg;

  // Value held by every entry that has no dedicated reset value.
  localparam int DEFAULT_ENTRY = 1;

  // Widest entry the reset-value helper can describe; callers truncate.
  localparam int MAX_PC_W = 64;

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reset contents of entry 'index' at full width. Entry 0 is -4 (all ones
  // except the two LSBs), entries 1 and 2 are small forward offsets, and the
  // rest fall back to DEFAULT_ENTRY.
  function automatic logic [MAX_PC_W-1:0] default_entry(input int index);
    logic [MAX_PC_W-1:0] value;
    case (index)
      0:       value = ~64'd3;
      1:       value = 64'd3;
      2:       value = 64'd7;
      default: value = 64'(DEFAULT_ENTRY);
    endcase
    return value;
  endfunction

endpackage

// File: rtl/target_lut_mem.sv
// Target table storage: DEPTH x PC_width flops with per-entry reset defaults,
// one synchronous write port and one combinational read port. A write and a
// read of the same entry in one cycle return the old contents.
module target_lut_mem
  import target_lut_pkg::*;
#(
  parameter int PC_width   = 10,
  parameter int ADDR_width = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_width-1:0] waddr,
  input  logic [PC_width-1:0]   wdata,
  input  logic [ADDR_width-1:0] raddr,
  output logic [PC_width-1:0]   rdata
);

  localparam int DEPTH = 1 << ADDR_width;

  logic [PC_width-1:0] entry [DEPTH];

  // Entries reload their defaults only on reset; otherwise one write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= PC_width'(default_entry(i));
      end
    end else if (we) begin
      entry[waddr] <= wdata;
    end
  end

  assign rdata = entry[raddr];

endmodule

// File: rtl/target_lut.sv
// Programmable branch/immediate target table for the fetch stage.
// A narrow index selects a full-width entry; the registered read result is the
// entry itself or pc + entry (modulo 2**PC_width). The table is refilled in
// index order through a load stream.
//
// Load handshake: a beat transfers when load_valid and load_ready are both
// high on a rising Clk edge and load_start is low in that cycle. load_ready is
// registered and is high only in LOAD; load_valid may toggle freely and
// load_data is only looked at on a beat. load_start takes priority over any
// beat presented in the same cycle.
//
// Optional feature macro: TARGET_LUT_BYPASS_EN. When defined, a read that hits
// the index being written by a same-cycle beat returns load_data; otherwise it
// returns the pre-write entry.
module target_lut
  import target_lut_pkg::*;
#(
  parameter int PC_width   = 10,
  parameter int ADDR_width = 3
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [PC_width-1:0]   load_data,
  output logic                  load_ready,
  output logic                  loaded,
  input  logic                  rd_en,
  input  logic [ADDR_width-1:0] addr,
  input  logic                  rel,
  input  logic [PC_width-1:0]   pc,
  output logic [PC_width-1:0]   datOut,
  output logic                  dat_valid,
  output state_t                state
);

  state_t                state_nx;
  logic [ADDR_width-1:0] idx;
  logic                  beat;
  logic                  last_beat;
  logic                  ready_nx;
  logic                  loaded_nx;
  logic [PC_width-1:0]   entry_rd;
  logic [PC_width-1:0]   entry_sel;
  logic [PC_width-1:0]   rel_sum;

  // A beat only exists while LOAD advertises ready and no restart is pending.
  assign beat      = load_valid & load_ready & ~load_start;
  assign last_beat = beat & (idx == {ADDR_width{1'b1}});

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: load_start always (re)enters LOAD; the last beat ends it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (load_start) state_nx = LOAD;
      end
      LOAD: begin
        if (load_start)     state_nx = LOAD;
        else if (last_beat) state_nx = DONE;
      end
      DONE: begin
        if (load_start) state_nx = LOAD;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output decode from the next state so the registered flags move on the
  // same edge as the state.
  always_comb begin
    ready_nx  = 1'b0;
    loaded_nx = 1'b0;
    case (state_nx)
      LOAD:    ready_nx  = 1'b1;
      DONE:    loaded_nx = 1'b1;
      default: begin
        ready_nx  = 1'b0;
        loaded_nx = 1'b0;
      end
    endcase
  end

  // Registered handshake/status flags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      load_ready <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      load_ready <= ready_nx;
      loaded     <= loaded_nx;
    end
  end

  // Write index: cleared by load_start, advanced by each accepted beat.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx <= '0;
    end else if (load_start) begin
      idx <= '0;
    end else if (beat) begin
      idx <= idx + ADDR_width'(1);
    end
  end

  target_lut_mem #(
    .PC_width  (PC_width),
    .ADDR_width(ADDR_width)
  ) u_mem (
    .clk  (Clk),
    .rst_n(Reset_n),
    .we   (beat),
    .waddr(idx),
    .wdata(load_data),
    .raddr(addr),
    .rdata(entry_rd)
  );

`ifdef TARGET_LUT_BYPASS_EN
  logic collide;
  assign collide = beat & (idx == addr);

  // Forward the beat's data when it targets the entry being read.
  always_comb begin
    entry_sel = entry_rd;
    if (collide) entry_sel = load_data;
  end
`else
  // Without forwarding a colliding read sees the stored (pre-write) entry.
  always_comb begin
    entry_sel = entry_rd;
  end
`endif

  // PC-relative add wraps at PC_width bits; the carry is dropped.
  assign rel_sum = pc + entry_sel;

  // Registered read port: update only on a request, valid follows rd_en.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      datOut    <= '0;
      dat_valid <= 1'b0;
    end else begin
      dat_valid <= rd_en;
      if (rd_en) begin
        datOut <= rel ? rel_sum : entry_sel;
      end
    end
  end

endmodule
